// File: rtl/upload_out_req_fifo.sv
// ---------------------------------------------------------------------------
// upload_out_req_fifo
//
// Local out-request FIFO between the upload flit FSM and the ring injection
// port. Flits are accepted one per cycle and released to the ring only once a
// whole packet (head..tail) is buffered, so a packet never stalls mid-ring
// waiting on upstream flits.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en_flit_in        upstream strobe; flit_in/ctrl_in valid this cycle
//   flit_in           flit data from the upload FSM datapath
//   ctrl_in           00 none, 01 head, 10 body, 11 tail
//   out_req_fifo_rdy  space for at least one flit (back-pressure to upload FSM)
//   ring_rdy          ring injection port accepts a flit this cycle
//   flit_out          flit at FIFO head
//   ctrl_out          ctrl of flit at FIFO head
//   flit_out_vld      flit_out/ctrl_out valid for transfer
//   pkt_cnt           complete packets buffered whose tail is not yet popped
//   fifo_state_out    drain FSM state (0 IDLE, 1 SEND)
//   err_overflow      sticky; push attempted while full
//   err_proto         sticky; ctrl framing violation on input
// ---------------------------------------------------------------------------
module upload_out_req_fifo #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_flit_in,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic [1:0]        ctrl_in,
    output logic              out_req_fifo_rdy,
    input  logic              ring_rdy,
    output logic [FLIT_W-1:0] flit_out,
    output logic [1:0]        ctrl_out,
    output logic              flit_out_vld,
    output logic [PTR_W:0]    pkt_cnt,
    output logic              fifo_state_out,
    output logic              err_overflow,
    output logic              err_proto
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_TAIL = 2'b11;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [FLIT_W+1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W:0]    pkt_cnt_q, pkt_cnt_d;
    logic              in_pkt_q, in_pkt_d;
    state_t            state_q, state_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_proto_q, err_proto_d;

    logic              push, accept, pop, full, vld;
    logic [1:0]        head_ctrl;

    assign full      = (count_q == FULL_CNT);
    assign push      = en_flit_in && (ctrl_in != 2'b00);
    assign accept    = push && !full;
    assign head_ctrl = mem_q[rd_ptr_q][FLIT_W+1:FLIT_W];

    // IDLE waits for a complete packet; SEND streams the rest of the current
    // one. The count guard keeps a malformed stream from popping an empty FIFO.
    assign vld = (count_q != '0) && ((state_q == SEND) || (pkt_cnt_q != '0));
    assign pop = vld && ring_rdy;

    assign out_req_fifo_rdy = !full;
    assign flit_out         = mem_q[rd_ptr_q][FLIT_W-1:0];
    assign ctrl_out         = head_ctrl;
    assign flit_out_vld     = vld;
    assign pkt_cnt          = pkt_cnt_q;
    assign fifo_state_out   = (state_q == SEND);
    assign err_overflow     = err_ovf_q;
    assign err_proto        = err_proto_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_cnt_d   = pkt_cnt_q;
        in_pkt_d    = in_pkt_q;
        state_d     = state_q;
        err_ovf_d   = err_ovf_q;
        err_proto_d = err_proto_q;

        if (push && full) begin
            err_ovf_d = 1'b1;
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if ((ctrl_in == CTRL_HEAD && in_pkt_q) || (ctrl_in[1] && !in_pkt_q)) begin
                err_proto_d = 1'b1;
            end
            if (ctrl_in == CTRL_HEAD) begin
                in_pkt_d = 1'b1;
            end else if (ctrl_in == CTRL_TAIL) begin
                in_pkt_d = 1'b0;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            case (state_q)
                IDLE: if (head_ctrl == CTRL_HEAD) state_d = SEND;
                SEND: if (head_ctrl == CTRL_TAIL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({accept && (ctrl_in == CTRL_TAIL), pop && (head_ctrl == CTRL_TAIL)})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_cnt_q   <= '0;
            in_pkt_q    <= 1'b0;
            state_q     <= IDLE;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_cnt_q   <= pkt_cnt_d;
            in_pkt_q    <= in_pkt_d;
            state_q     <= state_d;
            err_ovf_q   <= err_ovf_d;
            err_proto_q <= err_proto_d;
        end
    end

    // Storage is cleared on reset so flit_out/ctrl_out read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_ptr_q] <= {ctrl_in, flit_in};
        end
    end

endmodule

// File: tb/tb_upload_out_req_fifo.sv
module tb_upload_out_req_fifo;

    localparam int FLIT_W = 16;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en_flit_in = 1'b0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic [1:0]        ctrl_in = '0;
    logic              out_req_fifo_rdy;
    logic              ring_rdy = 1'b0;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        ctrl_out;
    logic              flit_out_vld;
    logic [PTR_W:0]    pkt_cnt;
    logic              fifo_state_out;
    logic              err_overflow;
    logic              err_proto;

    upload_out_req_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .en_flit_in(en_flit_in), .flit_in(flit_in),
        .ctrl_in(ctrl_in), .out_req_fifo_rdy(out_req_fifo_rdy), .ring_rdy(ring_rdy),
        .flit_out(flit_out), .ctrl_out(ctrl_out), .flit_out_vld(flit_out_vld),
        .pkt_cnt(pkt_cnt), .fifo_state_out(fifo_state_out),
        .err_overflow(err_overflow), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored {ctrl,flit} plus packet bookkeeping.
    logic [17:0] q[$];
    int          m_pkts;
    bit          m_inpkt, m_sending, m_eovf, m_eproto;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pkts = 0; m_inpkt = 0; m_sending = 0; m_eovf = 0; m_eproto = 0;
    endtask

    function automatic bit m_vld();
        return (q.size() != 0) && (m_sending || m_pkts != 0);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ":rdy"},   32'(out_req_fifo_rdy), 32'(q.size() != DEPTH));
        chk({tag, ":vld"},   32'(flit_out_vld),     32'(m_vld()));
        chk({tag, ":pkt"},   32'(pkt_cnt),          32'(m_pkts));
        chk({tag, ":state"}, 32'(fifo_state_out),   32'(m_sending));
        chk({tag, ":eovf"},  32'(err_overflow),     32'(m_eovf));
        chk({tag, ":eprot"}, 32'(err_proto),        32'(m_eproto));
        if (q.size() != 0) begin
            chk({tag, ":head"}, 32'({ctrl_out, flit_out}), 32'(q[0]));
        end
    endtask

    // Drive one cycle's inputs, check outputs, advance model and clock.
    task automatic step(input string tag, input bit en, input logic [15:0] f,
                        input logic [1:0] c, input bit rr);
        bit          pop, push, acc;
        logic [17:0] popped;
        en_flit_in = en; flit_in = f; ctrl_in = c; ring_rdy = rr;
        #1;
        check_outputs(tag);
        pop  = m_vld() && rr;
        push = en && (c != 2'b00);
        acc  = push && (q.size() < DEPTH);
        if (push && !acc) m_eovf = 1;
        if (acc) begin
            if ((c == 2'b01 && m_inpkt) || (c[1] && !m_inpkt)) m_eproto = 1;
            if (c == 2'b01) m_inpkt = 1;
            if (c == 2'b11) begin m_inpkt = 0; m_pkts++; end
        end
        popped = '0;
        if (pop) popped = q.pop_front();
        if (acc) q.push_back({c, f});
        if (pop) begin
            if (popped[17:16] == 2'b01) m_sending = 1;
            if (popped[17:16] == 2'b11) begin m_sending = 0; m_pkts--; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_flit_in = 0; ring_rdy = 0; ctrl_in = '0; flit_in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst:flit", 32'(flit_out), 32'h0);
        chk("rst:ctrl", 32'(ctrl_out), 32'h0);
        check_outputs("rst");
    endtask

    initial begin
        bit          gin;
        logic [1:0]  c;
        bit          en;
        model_reset();
        do_reset();

        // Basic 3-flit packet then drain.
        step("p1", 1, 16'h1234, 2'b01, 1);
        step("p1", 1, 16'h0001, 2'b10, 1);
        step("p1", 1, 16'h0002, 2'b11, 1);
        for (int i = 0; i < 4; i++) step("p1d", 0, '0, 2'b00, 1);

        // Fill to full, overflow, drain.
        step("full", 1, 16'hA000, 2'b01, 0);
        for (int i = 1; i <= 14; i++) step("full", 1, 16'(16'hA000 + i), 2'b10, 0);
        step("full", 1, 16'hA00F, 2'b11, 0);
        step("ovf", 1, 16'hBEEF, 2'b01, 0);
        step("ovf", 0, '0, 2'b00, 0);
        for (int i = 0; i < 18; i++) step("fdrain", 0, '0, 2'b00, 1);

        // Strobes with ctrl 00 inside a packet are ignored.
        step("nul", 1, 16'h0101, 2'b01, 0);
        step("nul", 1, 16'hDEAD, 2'b00, 0);
        step("nul", 1, 16'h0102, 2'b10, 0);
        step("nul", 1, 16'hDEAD, 2'b00, 0);
        step("nul", 1, 16'h0103, 2'b11, 0);
        for (int i = 0; i < 5; i++) step("nuld", 0, '0, 2'b00, 1);

        // Back-to-back packets: tail pop of first coincides with tail push of second.
        step("b2b", 1, 16'h0A01, 2'b01, 1);
        step("b2b", 1, 16'h0A02, 2'b11, 1);
        step("b2b", 1, 16'h0B01, 2'b01, 1);
        step("b2b", 1, 16'h0B02, 2'b11, 1);
        chk("b2b:pkt_stays1", 32'(pkt_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step("b2bd", 0, '0, 2'b00, 1);

        // Body without head: protocol error, flit still stored.
        step("prot", 1, 16'h0C01, 2'b10, 0);
        step("prot", 0, '0, 2'b00, 0);
        chk("prot:sticky", 32'(err_proto), 32'd1);
        step("prot", 1, 16'h0C02, 2'b01, 0);
        step("prot", 1, 16'h0C03, 2'b11, 0);
        for (int i = 0; i < 5; i++) step("protd", 0, '0, 2'b00, 1);

        // Asynchronous reset mid-packet while in SEND with 3 flits left.
        do_reset();
        step("ar", 1, 16'h0D01, 2'b01, 0);
        step("ar", 1, 16'h0D02, 2'b10, 0);
        step("ar", 1, 16'h0D03, 2'b10, 0);
        step("ar", 1, 16'h0D04, 2'b11, 0);
        step("ar", 0, '0, 2'b00, 1);
        chk("ar:send", 32'(fifo_state_out), 32'd1);
        en_flit_in = 0; ring_rdy = 1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("ar:flit", 32'(flit_out), 32'h0);
        chk("ar:ctrl", 32'(ctrl_out), 32'h0);
        check_outputs("ar_now");
        @(posedge clk); #1;
        rst = 1'b0;
        step("arpost", 1, 16'h0E01, 2'b01, 1);
        step("arpost", 1, 16'h0E02, 2'b11, 1);
        for (int i = 0; i < 3; i++) step("arpostd", 0, '0, 2'b00, 1);

        // Randomized well-formed traffic with null strobes and ring stalls.
        do_reset();
        gin = 0;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) c = 2'b00;
            else if (!gin) c = 2'b01;
            else c = (($urandom % 3) == 0) ? 2'b11 : 2'b10;
            if (en && c == 2'b01) gin = 1;
            if (en && c == 2'b11) gin = 0;
            step("rnd", en, 16'($urandom), c, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 40; i++) step("rndd", 0, '0, 2'b00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
